// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive monitor: parity modes, FSM state
// encoding and the bit-period helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic int calc_bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head
// entry is presented on rd_data_o whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty, full, pop, push;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign pop   = rd_en_i && !empty;
    // A full FIFO still takes the write when the same cycle frees the head slot.
    assign push       = wr_en_i && (!full || pop);
    assign overflow_o = wr_en_i && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign rd_valid_o = !empty;
    assign count_o    = count_q;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver with configurable frame format, error pulses and FWFT receive
// FIFO. Define UART_RX_MONITOR_PRINT_EN to echo received characters in simulation.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic                        rd_en,
    output logic [DATA_BITS-1:0]        rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow
);
    localparam int   BIT_CYCLES  = calc_bit_cycles(CLK_FREQ, BAUD);
    localparam int   HALF_CYCLES = BIT_CYCLES / 2;
    localparam int   CW          = $clog2(BIT_CYCLES);
    localparam logic ODD_SENSE   = (PARITY == PAR_ODD);

    logic                 meta_q, sync_q, prev_q;
    logic                 rx_s, fall;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_err;
    logic                 done, done_ferr, done_perr, push;
    logic                 fifo_ovf;
    logic                 frame_err_q, parity_err_q, overflow_q;

    assign rx_s     = sync_q;
    assign fall     = prev_q && !sync_q;
    assign stop_err = ferr_q || !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done       = 1'b0;
        done_ferr  = 1'b0;
        done_perr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = CW'(HALF_CYCLES - 1);
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s) begin
                    // Line back high at mid start bit: a glitch, not a frame.
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_DATA;
                    cnt_d      = CW'(BIT_CYCLES - 1);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d     = CW'(BIT_CYCLES - 1);
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ rx_s;
                    bit_idx_d = bit_idx_q + 3'(1);
                    if (bit_idx_q == 3'(DATA_BITS - 1))
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = CW'(BIT_CYCLES - 1);
                    perr_d  = rx_s ^ par_acc_q ^ ODD_SENSE;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                    done      = 1'b1;
                    done_ferr = stop_err;
                    done_perr = perr_q;
                    state_d   = stop_err ? S_WAIT_HIGH : S_IDLE;
                end else begin
                    ferr_d     = stop_err;
                    stop_idx_d = 1'b1;
                    cnt_d      = CW'(BIT_CYCLES - 1);
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must release before a new start is armed.
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            par_acc_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            par_acc_q    <= par_acc_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            frame_err_q  <= done && done_ferr;
            parity_err_q <= done && done_perr;
            overflow_q   <= fifo_ovf;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign push = done && !done_ferr && !done_perr;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (push),
        .wr_data_i  (shift_q),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .count_o    (fifo_count),
        .overflow_o (fifo_ovf)
    );

    assign busy       = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

`ifdef UART_RX_MONITOR_PRINT_EN
    logic [7:0] print_byte;
    assign print_byte = 8'(shift_q);

    always @(posedge clk) begin
        if (!rst) begin
            if (push && !fifo_ovf) begin
                $write("%c", print_byte);
                if (print_byte == 8'h0A) $display("[%t] line done", $time);
            end
            if (frame_err_q)  $display("[%t] uart_rx_monitor warning: frame error", $time);
            if (parity_err_q) $display("[%t] uart_rx_monitor warning: parity error", $time);
            if (overflow_q)   $display("[%t] uart_rx_monitor warning: byte dropped, fifo full", $time);
        end
    end
`else
    // Synthesizable build: received bytes are only visible through the FIFO.
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed self-checking bench: four receiver instances cover default format,
// even parity, framing/overflow with a 4-deep FIFO, and 7-bit/2-stop reset abort.
module tb_uart_rx_monitor;

    localparam int B0 = 434;
    localparam int BF = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rxd_v;
    logic [3:0] rd_en_v;

    logic [7:0] rd_data0, rd_data1, rd_data2;
    logic [6:0] rd_data3;
    logic       rd_valid0, rd_valid1, rd_valid2, rd_valid3;
    logic [4:0] cnt0, cnt1, cnt3;
    logic [2:0] cnt2;
    logic       busy0, busy1, busy2, busy3;
    logic       fe0, fe1, fe2, fe3, pe0, pe1, pe2, pe3, ov0, ov1, ov2, ov3;

    int checks   = 0;
    int failures = 0;
    int fe_n[4]  = '{default: 0};
    int pe_n[4]  = '{default: 0};
    int ov_n[4]  = '{default: 0};

    uart_rx_monitor u0 (
        .clk(clk), .rst(rst), .rxd(rxd_v[0]), .rd_en(rd_en_v[0]),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(cnt0), .busy(busy0),
        .frame_err(fe0), .parity_err(pe0), .overflow(ov0)
    );

    uart_rx_monitor #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .rxd(rxd_v[1]), .rd_en(rd_en_v[1]),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(cnt1), .busy(busy1),
        .frame_err(fe1), .parity_err(pe1), .overflow(ov1)
    );

    uart_rx_monitor #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .rxd(rxd_v[2]), .rd_en(rd_en_v[2]),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .fifo_count(cnt2), .busy(busy2),
        .frame_err(fe2), .parity_err(pe2), .overflow(ov2)
    );

    uart_rx_monitor #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .rxd(rxd_v[3]), .rd_en(rd_en_v[3]),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .fifo_count(cnt3), .busy(busy3),
        .frame_err(fe3), .parity_err(pe3), .overflow(ov3)
    );

    logic [3:0] fe_v, pe_v, ov_v;
    assign fe_v = {fe3, fe2, fe1, fe0};
    assign pe_v = {pe3, pe2, pe1, pe0};
    assign ov_v = {ov3, ov2, ov1, ov0};

    // Each high cycle of a pulse output counts once.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fe_v[i]) fe_n[i] <= fe_n[i] + 1;
            if (pe_v[i]) pe_n[i] <= pe_n[i] + 1;
            if (ov_v[i]) ov_n[i] <= ov_n[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        rxd_v[inst] = v;
    endtask

    // pmode: 0 none, 1 odd, 2 even, 3 parity bit forced to 1
    task automatic send_frame(input int inst, input logic [7:0] data, input int nbits,
                              input int pmode, input int nstops, input logic stop_val,
                              input int bc);
        logic [7:0] m;
        logic       p;
        m = data & ((8'd1 << nbits) - 8'd1);
        set_line(inst, 1'b0);
        tick(bc);
        for (int i = 0; i < nbits; i++) begin
            set_line(inst, m[i]);
            tick(bc);
        end
        if (pmode != 0) begin
            case (pmode)
                1:       p = ~(^m);
                2:       p = ^m;
                default: p = 1'b1;
            endcase
            set_line(inst, p);
            tick(bc);
        end
        for (int i = 0; i < nstops; i++) begin
            set_line(inst, stop_val);
            tick(bc);
        end
    endtask

    task automatic pop0(input logic [7:0] exp, input string tag);
        chk({tag, " valid"}, rd_valid0, 1);
        chk({tag, " data"}, rd_data0, exp);
        rd_en_v[0] = 1'b1;
        tick(1);
        rd_en_v[0] = 1'b0;
    endtask

    task automatic pop2(input logic [7:0] exp, input string tag);
        chk({tag, " valid"}, rd_valid2, 1);
        chk({tag, " data"}, rd_data2, exp);
        rd_en_v[2] = 1'b1;
        tick(1);
        rd_en_v[2] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst     = 1'b1;
        rxd_v   = 4'hF;
        rd_en_v = 4'h0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        chk("rst u0 rd_valid", rd_valid0, 0);
        chk("rst u0 rd_data", rd_data0, 0);
        chk("rst u0 count", cnt0, 0);
        chk("rst u0 busy", busy0, 0);
        chk("rst u0 pulses", {fe0, pe0, ov0}, 0);
        chk("rst u2 count", cnt2, 0);
        chk("rst u3 busy", busy3, 0);

        // Default 8N1 at 434 cycles/bit: completion edge is 3 + 217 + 9*434 after start drive
        fork
            send_frame(0, 8'h55, 8, 0, 1, 1'b1, B0);
            begin
                tick(4125);
                chk("u0 latency before", rd_valid0, 0);
                tick(1);
                chk("u0 latency after", rd_valid0, 1);
            end
        join
        tick(2);
        chk("u0 first data", rd_data0, 8'h55);
        chk("u0 count 1", cnt0, 1);
        send_frame(0, 8'h0A, 8, 0, 1, 1'b1, B0);
        tick(2);
        chk("u0 count 2", cnt0, 2);
        pop0(8'h55, "u0 pop 55");
        pop0(8'h0A, "u0 pop 0A");
        chk("u0 drained count", cnt0, 0);
        chk("u0 drained valid", rd_valid0, 0);
        chk("u0 no frame_err", fe_n[0], 0);
        chk("u0 no parity_err", pe_n[0], 0);
        chk("u0 no overflow", ov_n[0], 0);

        // 100-cycle glitch on idle line
        set_line(0, 1'b0);
        tick(50);
        chk("glitch busy seen", busy0, 1);
        tick(50);
        set_line(0, 1'b1);
        w = 0;
        while (busy0 && w < 217) begin
            tick(1);
            w++;
        end
        chk("glitch busy drop", busy0, 0);
        tick(5);
        chk("glitch fifo empty", rd_valid0, 0);
        chk("glitch no pulses", fe_n[0] + pe_n[0] + ov_n[0], 0);

        // Even parity: forced-wrong parity then a good frame
        send_frame(1, 8'hA5, 8, 3, 1, 1'b1, BF);
        tick(3);
        chk("par err pulse", pe_n[1], 1);
        chk("par no frame_err", fe_n[1], 0);
        chk("par fifo empty", cnt1, 0);
        tick(BF);
        send_frame(1, 8'h3C, 8, 2, 1, 1'b1, BF);
        tick(3);
        chk("par good valid", rd_valid1, 1);
        chk("par good data", rd_data1, 8'h3C);
        chk("par err still 1", pe_n[1], 1);

        // Bad stop bit followed by a 3-bit-time break
        send_frame(2, 8'h12, 8, 0, 1, 1'b0, BF);
        tick(3 * BF);
        chk("frame busy in break", busy2, 1);
        chk("frame err pulse", fe_n[2], 1);
        chk("frame no parity_err", pe_n[2], 0);
        chk("frame fifo empty", rd_valid2, 0);
        set_line(2, 1'b1);
        tick(BF);
        chk("frame idle after release", busy2, 0);
        send_frame(2, 8'h34, 8, 0, 1, 1'b1, BF);
        tick(3);
        chk("frame next count", cnt2, 1);
        pop2(8'h34, "frame next pop");
        chk("frame err still 1", fe_n[2], 1);

        // Overflow with a 4-deep FIFO, frames back to back
        for (int i = 1; i <= 5; i++) send_frame(2, 8'(i), 8, 0, 1, 1'b1, BF);
        tick(3);
        chk("ovf pulse", ov_n[2], 1);
        chk("ovf count full", cnt2, 4);
        for (int i = 1; i <= 4; i++) pop2(8'(i), "ovf pop");
        chk("ovf drained", cnt2, 0);
        for (int i = 1; i <= 4; i++) send_frame(2, 8'(8'h10 + i), 8, 0, 1, 1'b1, BF);
        tick(3);
        chk("refill count", cnt2, 4);
        // rd_en held across the completion edge (3 + 8 + 9*16 after start drive)
        fork
            send_frame(2, 8'h15, 8, 0, 1, 1'b1, BF);
            begin
                tick(154);
                rd_en_v[2] = 1'b1;
                tick(1);
                rd_en_v[2] = 1'b0;
            end
        join
        tick(1);
        chk("push+pop full count", cnt2, 4);
        chk("push+pop no overflow", ov_n[2], 1);
        for (int i = 2; i <= 5; i++) pop2(8'(8'h10 + i), "push+pop drain");
        chk("push+pop drained", cnt2, 0);

        // 7 data bits, 2 stop bits, reset mid-frame
        send_frame(3, 8'h7F, 7, 0, 2, 1'b1, BF);
        tick(3);
        chk("d7 first count", cnt3, 1);
        chk("d7 first data", rd_data3, 7'h7F);
        set_line(3, 1'b0);
        tick(3 * BF);
        chk("d7 busy midframe", busy3, 1);
        set_line(3, 1'b1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("d7 rst busy", busy3, 0);
        chk("d7 rst valid", rd_valid3, 0);
        chk("d7 rst count", cnt3, 0);
        chk("d7 rst data", rd_data3, 0);
        chk("d7 rst pulses", {fe3, pe3, ov3}, 0);
        tick(2 * BF);
        chk("d7 idle after rst", busy3, 0);
        send_frame(3, 8'hFF, 7, 0, 2, 1'b1, BF);
        tick(3);
        chk("d7 count", cnt3, 1);
        chk("d7 zero-extended", {1'b0, rd_data3}, 8'h7F);
        chk("d7 no pulses", fe_n[3] + pe_n[3] + ov_n[3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
